// File: rtl/stage_pkg.sv
// Shared types for the game-flow sequencer: stage encoding, HUD countdown width
// and the screen-enable decode used by the display mux.
package stage_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        INTRO     = 3'd1,
        PLAY      = 3'd2,
        RESULT    = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } stage_t;

    localparam int COUNTDOWN_W = 4;
    localparam int SCREEN_W    = 5;

    // Bit order {win, gameOver, result, intro, menu}; PLAY shows the game itself.
    function automatic logic [SCREEN_W-1:0] screen_enables(input stage_t s);
        logic [SCREEN_W-1:0] v;
        case (s)
            MENU:      v = 5'b00001;
            INTRO:     v = 5'b00010;
            RESULT:    v = 5'b00100;
            GAME_OVER: v = 5'b01000;
            WIN:       v = 5'b10000;
            default:   v = 5'b00000;
        endcase
        return v;
    endfunction

    // Stages in which the one-second divider is allowed to run.
    function automatic logic is_timed(input stage_t s);
        logic t;
        case (s)
            INTRO, PLAY, RESULT: t = 1'b1;
            default:             t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second divider: registered one-clock pulse on the last count of each
// period, synchronous clear to restart a full period, and hold to freeze it.
module sec_tick_gen #(
    parameter int CLKS_PER_SEC = 31500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic pulse
);

    localparam int               CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic [CNT_W-1:0] w_cnt_next;

    // Free-running successor of the counter, wrapping after the last count.
    always_comb begin
        if (r_cnt == LAST) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Pulse is registered against the count it accompanies, so it is high
    // exactly in the cycle where the counter sits at CLKS_PER_SEC-1.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (hold) begin
            r_cnt   <= r_cnt;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_pulse <= (w_cnt_next == LAST);
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/stage_sequencer.sv
// Game-flow sequencer feeding the level controller and display mux.
// Optional pause support (pauseKey input) is built when STAGE_PAUSE_EN is defined.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter  int CLKS_PER_SEC   = 31500000,
    parameter  int NUM_LEVELS     = 4,
    parameter  int INTRO_SECONDS  = 3,
    parameter  int RESULT_SECONDS = 2,
    localparam int LVL_W          = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startKey,
`ifdef STAGE_PAUSE_EN
    input  logic                   pauseKey,
`endif
    input  logic                   stageEnded,
    input  logic                   stageFailed,
    input  logic                   lastLevelEnded,
    output logic                   levelEnable,
    output logic                   cycleLevel,
    output logic                   oneSecPulse,
    output logic [LVL_W-1:0]       levelIndex,
    output logic [COUNTDOWN_W-1:0] countdown,
    output logic                   menuEn,
    output logic                   introEn,
    output logic                   resultEn,
    output logic                   gameOverEn,
    output logic                   winEn
);

    localparam logic [LVL_W-1:0]       LAST_LVL  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [COUNTDOWN_W-1:0] CD_INTRO  = COUNTDOWN_W'(INTRO_SECONDS);
    localparam logic [COUNTDOWN_W-1:0] CD_RESULT = COUNTDOWN_W'(RESULT_SECONDS);
    localparam logic [COUNTDOWN_W-1:0] CD_ONE    = COUNTDOWN_W'(1);

    stage_t                 r_state;
    logic                   r_start_hist;
    logic [LVL_W-1:0]       r_level_idx;
    logic [COUNTDOWN_W-1:0] r_countdown;
    logic                   r_cycle_level;
    logic                   r_level_en;
    logic [SCREEN_W-1:0]    r_screen;

    stage_t                 w_state_next;
    logic [LVL_W-1:0]       w_level_next;
    logic [COUNTDOWN_W-1:0] w_count_next;
    logic                   w_cycle_next;
    logic                   w_start_edge;
    logic                   w_tick;
    logic                   w_clear;
    logic                   w_hold;

    assign w_start_edge = startKey & ~r_start_hist;

    // Next-state and next-value logic; outputs are registered from these.
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level_idx;
        w_count_next = r_countdown;
        w_cycle_next = 1'b0;
        case (r_state)
            MENU: begin
                if (w_start_edge) begin
                    w_state_next = INTRO;
                    w_level_next = '0;
                    w_count_next = CD_INTRO;
                end else begin
                    w_state_next = MENU;
                end
            end
            INTRO: begin
                if (w_tick) begin
                    if (r_countdown <= CD_ONE) begin
                        w_state_next = PLAY;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_countdown - CD_ONE;
                    end
                end else begin
                    w_count_next = r_countdown;
                end
            end
            PLAY: begin
                if (stageFailed) begin
                    w_state_next = GAME_OVER;
                end else if (stageEnded) begin
                    if (lastLevelEnded || (r_level_idx == LAST_LVL)) begin
                        w_state_next = WIN;
                    end else begin
                        w_state_next = RESULT;
                        w_count_next = CD_RESULT;
                    end
                end else begin
                    w_state_next = PLAY;
                end
            end
            RESULT: begin
                if (w_tick) begin
                    if (r_countdown <= CD_ONE) begin
                        w_state_next = INTRO;
                        w_count_next = CD_INTRO;
                        w_cycle_next = 1'b1;
                        // The last level exits via WIN, so this only guards saturation.
                        if (r_level_idx == LAST_LVL) begin
                            w_level_next = r_level_idx;
                        end else begin
                            w_level_next = r_level_idx + 1'b1;
                        end
                    end else begin
                        w_count_next = r_countdown - CD_ONE;
                    end
                end else begin
                    w_count_next = r_countdown;
                end
            end
            GAME_OVER, WIN: begin
                if (w_start_edge) begin
                    w_state_next = MENU;
                    w_level_next = '0;
                end else begin
                    w_state_next = r_state;
                end
            end
            default: begin
                w_state_next = MENU;
                w_level_next = '0;
                w_count_next = '0;
            end
        endcase
    end

    // Divider restarts on entry to a timed stage and stays idle outside them.
    assign w_clear = ~is_timed(w_state_next) | (w_state_next != r_state);

`ifdef STAGE_PAUSE_EN
    logic r_pause_hist;
    logic r_paused;
    logic w_paused_next;

    // Pause toggles on a key edge and is only meaningful in timed stages.
    always_comb begin
        if (is_timed(w_state_next)) begin
            w_paused_next = r_paused ^ (pauseKey & ~r_pause_hist);
        end else begin
            w_paused_next = 1'b0;
        end
    end

    // Pause key history and paused flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause_hist <= 1'b0;
            r_paused     <= 1'b0;
        end else begin
            r_pause_hist <= pauseKey;
            r_paused     <= w_paused_next;
        end
    end

    // Hold uses the next paused value so the pulse is suppressed in every paused cycle.
    assign w_hold = w_paused_next;
`else
    assign w_hold = 1'b0;
`endif

    sec_tick_gen #(
        .CLKS_PER_SEC(CLKS_PER_SEC)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .hold  (w_hold),
        .pulse (w_tick)
    );

    // State register plus registered decode of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= MENU;
            r_start_hist  <= 1'b0;
            r_level_idx   <= '0;
            r_countdown   <= '0;
            r_cycle_level <= 1'b0;
            r_level_en    <= 1'b0;
            r_screen      <= screen_enables(MENU);
        end else begin
            r_state       <= w_state_next;
            r_start_hist  <= startKey;
            r_level_idx   <= w_level_next;
            r_countdown   <= w_count_next;
            r_cycle_level <= w_cycle_next;
            r_level_en    <= (w_state_next == PLAY);
            r_screen      <= screen_enables(w_state_next);
        end
    end

    assign levelEnable = r_level_en;
    assign cycleLevel  = r_cycle_level;
    assign oneSecPulse = w_tick;
    assign levelIndex  = r_level_idx;
    assign countdown   = r_countdown;
    assign menuEn      = r_screen[0];
    assign introEn     = r_screen[1];
    assign resultEn    = r_screen[2];
    assign gameOverEn  = r_screen[3];
    assign winEn       = r_screen[4];

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer with a small tick period;
// the pause scenario is included when STAGE_PAUSE_EN is defined.
module tb_stage_sequencer;

    localparam int CLKS     = 4;
    localparam int NLV      = 2;
    localparam int INTRO_S  = 2;
    localparam int RESULT_S = 1;

    localparam logic [4:0] S_MENU = 5'b00001;
    localparam logic [4:0] S_INTR = 5'b00010;
    localparam logic [4:0] S_RES  = 5'b00100;
    localparam logic [4:0] S_GO   = 5'b01000;
    localparam logic [4:0] S_WIN  = 5'b10000;
    localparam logic [4:0] S_PLAY = 5'b00000;

    logic       clk = 1'b0;
    logic       reset, startKey, stageEnded, stageFailed, lastLevelEnded;
`ifdef STAGE_PAUSE_EN
    logic       pauseKey;
`endif
    logic       levelEnable, cycleLevel, oneSecPulse;
    logic [0:0] levelIndex;
    logic [3:0] countdown;
    logic       menuEn, introEn, resultEn, gameOverEn, winEn;

    int total = 0;
    int bad = 0;
    int cyc_count = 0;
    int stray_pulse = 0;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    stage_sequencer #(
        .CLKS_PER_SEC   (CLKS),
        .NUM_LEVELS     (NLV),
        .INTRO_SECONDS  (INTRO_S),
        .RESULT_SECONDS (RESULT_S)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startKey       (startKey),
`ifdef STAGE_PAUSE_EN
        .pauseKey       (pauseKey),
`endif
        .stageEnded     (stageEnded),
        .stageFailed    (stageFailed),
        .lastLevelEnded (lastLevelEnded),
        .levelEnable    (levelEnable),
        .cycleLevel     (cycleLevel),
        .oneSecPulse    (oneSecPulse),
        .levelIndex     (levelIndex),
        .countdown      (countdown),
        .menuEn         (menuEn),
        .introEn        (introEn),
        .resultEn       (resultEn),
        .gameOverEn     (gameOverEn),
        .winEn          (winEn)
    );

    // Counts strobes and any tick seen outside INTRO/PLAY/RESULT.
    always @(negedge clk) begin
        if (cycleLevel === 1'b1) cyc_count++;
        if ((oneSecPulse === 1'b1) && !(introEn || resultEn || levelEnable)) stray_pulse++;
    end

    function automatic logic [11:0] observed();
        return {winEn, gameOverEn, resultEn, introEn, menuEn, levelEnable, levelIndex, countdown, oneSecPulse};
    endfunction

    function automatic logic [11:0] mk(input logic [4:0] scr, input logic le, input logic idx,
                                       input logic [3:0] cd, input logic p);
        return {scr, le, idx, cd, p};
    endfunction

    task automatic push_exp(input string tag, input logic [11:0] e);
        sb_q.push_back('{tag, e});
    endtask

    task automatic pop_cmp();
        exp_t        x;
        logic [11:0] o;
        x = sb_q.pop_front();
        o = observed();
        total++;
        assert (o === x.exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] e);
        push_exp(tag, e);
        pop_cmp();
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; startKey = 1'b0; stageEnded = 1'b0; stageFailed = 1'b0; lastLevelEnded = 1'b0;
`ifdef STAGE_PAUSE_EN
        pauseKey = 1'b0;
`endif
        tick(3);
        chk("reset", mk(S_MENU, 1'b0, 1'b0, 4'd0, 1'b0));
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_menu", mk(S_MENU, 1'b0, 1'b0, 4'd0, 1'b0));
        end

        // Key held for 10 cycles: one transition, PLAY exactly 8 cycles after INTRO entry.
        startKey = 1'b1;
        tick(1);
        for (int e = 0; e < 8; e++) begin
            chk("intro0", mk(S_INTR, 1'b0, 1'b0, (e < 4) ? 4'd2 : 4'd1, (e % 4 == 3)));
            tick(1);
        end
        chk("play0_entry", mk(S_PLAY, 1'b1, 1'b0, 4'd0, 1'b0));
        tick(1);
        startKey = 1'b0;
        for (int p = 1; p < 6; p++) begin
            chk("play0", mk(S_PLAY, 1'b1, 1'b0, 4'd0, (p == 3)));
            if (p < 5) tick(1);
        end

        stageEnded = 1'b1; tick(1); stageEnded = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk("result0", mk(S_RES, 1'b0, 1'b0, 4'd1, (r == 3)));
            tick(1);
        end
        chk("intro1_entry", mk(S_INTR, 1'b0, 1'b1, 4'd2, 1'b0));
        chk_int("cyclelevel_strobe", int'(cycleLevel), 1);
        for (int e = 1; e < 8; e++) begin
            tick(1);
            chk("intro1", mk(S_INTR, 1'b0, 1'b1, (e < 4) ? 4'd2 : 4'd1, (e % 4 == 3)));
        end
        tick(1);
        chk("play1_entry", mk(S_PLAY, 1'b1, 1'b1, 4'd0, 1'b0));
        chk_int("cyclelevel_once", cyc_count, 1);

        // Last level complete goes to WIN without a strobe; stray results ignored.
        stageEnded = 1'b1; tick(1); stageEnded = 1'b0;
        chk("win", mk(S_WIN, 1'b0, 1'b1, 4'd0, 1'b0));
        stageFailed = 1'b1; stageEnded = 1'b1; tick(1); stageFailed = 1'b0; stageEnded = 1'b0;
        tick(2);
        chk("win_stray", mk(S_WIN, 1'b0, 1'b1, 4'd0, 1'b0));
        chk_int("no_cycle_on_win", cyc_count, 1);
        startKey = 1'b1; tick(1); startKey = 1'b0;
        chk("win_to_menu", mk(S_MENU, 1'b0, 1'b0, 4'd0, 1'b0));

        // Simultaneous fail and end: fail wins.
        tick(2);
        startKey = 1'b1; tick(1); startKey = 1'b0;
        tick(8);
        chk("play0_again", mk(S_PLAY, 1'b1, 1'b0, 4'd0, 1'b0));
        stageFailed = 1'b1; stageEnded = 1'b1; tick(1); stageFailed = 1'b0; stageEnded = 1'b0;
        chk("fail_wins", mk(S_GO, 1'b0, 1'b0, 4'd0, 1'b0));
        startKey = 1'b1; tick(1);
        chk("go_to_menu", mk(S_MENU, 1'b0, 1'b0, 4'd0, 1'b0));
        tick(3);
        chk("held_no_retrigger", mk(S_MENU, 1'b0, 1'b0, 4'd0, 1'b0));
        startKey = 1'b0;

        // Reset one cycle before the terminal RESULT pulse.
        tick(1);
        startKey = 1'b1; tick(1); startKey = 1'b0;
        tick(8);
        stageEnded = 1'b1; tick(1); stageEnded = 1'b0;
        tick(2);
        chk("result_r2", mk(S_RES, 1'b0, 1'b0, 4'd1, 1'b0));
        reset = 1'b1; tick(1);
        chk("reset_mid", mk(S_MENU, 1'b0, 1'b0, 4'd0, 1'b0));
        chk_int("reset_no_cycle", int'(cycleLevel), 0);
        reset = 1'b0;
        tick(4);
        chk("after_reset", mk(S_MENU, 1'b0, 1'b0, 4'd0, 1'b0));
        chk_int("no_cycle_after_reset", cyc_count, 1);

`ifdef STAGE_PAUSE_EN
        // Ten paused cycles in INTRO delay PLAY from entry+8 to entry+18.
        startKey = 1'b1; tick(1); startKey = 1'b0;
        tick(1); pauseKey = 1'b1;
        tick(4); pauseKey = 1'b0;
        tick(6); pauseKey = 1'b1;
        tick(1); pauseKey = 1'b0;
        tick(5);
        chk("pause_e17", mk(S_INTR, 1'b0, 1'b0, 4'd1, 1'b1));
        tick(1);
        chk("pause_exit", mk(S_PLAY, 1'b1, 1'b0, 4'd0, 1'b0));
`endif

        chk_int("stray_pulse", stray_pulse, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
